// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the console FIFO read port and
// serializes each one as a start/data/stop asynchronous frame on tx.
module uart_tx_fifo_drain #(
    parameter int WIDTH         = 8,
    parameter int CLKS_PER_BIT  = 868,
    parameter int STOP_BITS     = 1,
    parameter int FETCH_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic             fifo_out_valid,
    input  logic [WIDTH-1:0] fifo_output,
    output logic             fifo_read_en,
    output logic             tx,
    output logic             tx_busy,
    output logic             frame_done,
    output logic             fetch_err
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;
    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [BW-1:0]      baud_cnt;
    logic [BW-1:0]      baud_n;
    logic [CW-1:0]      bit_cnt;
    logic [CW-1:0]      bit_n;
    logic [TW-1:0]      wait_cnt;
    logic [TW-1:0]      wait_n;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_n;
    logic               err_n;
    logic               baud_last;

    logic               tx_d;
    logic               read_en_d;
    logic               busy_d;
    logic               done_d;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // State, datapath and registered outputs all share one synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            shift_reg    <= '0;
            fetch_err    <= 1'b0;
            tx           <= 1'b1;
            fifo_read_en <= 1'b0;
            tx_busy      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_n;
            bit_cnt      <= bit_n;
            wait_cnt     <= wait_n;
            shift_reg    <= shift_n;
            fetch_err    <= err_n;
            tx           <= tx_d;
            fifo_read_en <= read_en_d;
            tx_busy      <= busy_d;
            frame_done   <= done_d;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        wait_n  = wait_cnt;
        shift_n = shift_reg;
        err_n   = fetch_err;
        unique case (state)
            S_IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                wait_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_out_valid) begin
                    shift_n = fifo_output;
                    baud_n  = '0;
                    state_n = S_START;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up
    // with the state they describe.
    always_comb begin
        tx_d      = 1'b1;
        read_en_d = (state_n == S_REQ);
        busy_d    = (state_n != S_IDLE);
        done_d    = (state_n == S_STOP) && (baud_n == BAUD_LAST)
                    && (bit_n == STOP_LAST);
        unique case (state_n)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_n[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: FIFO model plus frame decoder that checks
// serialized bytes, handshake timing, timeouts and reset recovery.
module tb_uart_tx_fifo_drain;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
    localparam int TO  = 4;
    localparam int FL  = (1 + W + SB) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_enable;
    logic         fifo_empty;
    logic         fifo_out_valid;
    logic [W-1:0] fifo_output;
    logic         fifo_read_en;
    logic         tx;
    logic         tx_busy;
    logic         frame_done;
    logic         fetch_err;

    uart_tx_fifo_drain #(
        .WIDTH(W), .CLKS_PER_BIT(CPB),
        .STOP_BITS(SB), .FETCH_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable),
        .fifo_empty(fifo_empty), .fifo_out_valid(fifo_out_valid),
        .fifo_output(fifo_output), .fifo_read_en(fifo_read_en),
        .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic [7:0] ex[$];
    bit th[$], rh[$], bh[$], dh[$];
    bit mute = 0, stray = 0, pend = 0, ren_prev = 0;
    logic [7:0] pend_data;

    typedef struct {
        bit         en;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        int         frames;
        int         gap;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // FIFO model: pops on a read-enable rising edge, returns data next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        fifo_out_valid = 1'b0;
        fifo_output    = 8'($urandom);
        if (pend) begin
            fifo_out_valid = 1'b1;
            fifo_output    = pend_data;
            pend           = 1'b0;
        end else if (stray && $urandom_range(0, 7) == 0) begin
            fifo_out_valid = 1'b1;
        end
        if (fifo_read_en && !ren_prev && q.size() > 0) begin
            pend_data = q.pop_front();
            pend      = !mute;
        end
        ren_prev   = fifo_read_en;
        fifo_empty = (q.size() == 0);
        th.push_back(tx);
        rh.push_back(fifo_read_en);
        bh.push_back(tx_busy);
        dh.push_back(frame_done);
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    function automatic int n_ren(int a);
        int n = 0;
        for (int i = a; i < rh.size(); i++) n += int'(rh[i]);
        return n;
    endfunction

    function automatic int n_adj(int a);
        int n = 0;
        for (int i = a + 1; i < rh.size(); i++) n += int'(rh[i] & rh[i-1]);
        return n;
    endfunction

    function automatic int n_busy(int a);
        int n = 0;
        for (int i = a; i < bh.size(); i++) n += int'(bh[i]);
        return n;
    endfunction

    function automatic int n_low(int a);
        int n = 0;
        for (int i = a; i < th.size(); i++) n += int'(!th[i]);
        return n;
    endfunction

    function automatic int first_ren(int a);
        for (int i = a; i < rh.size(); i++) if (rh[i]) return i;
        return -1;
    endfunction

    function automatic int first_low(int a);
        for (int i = a; i < th.size(); i++) if (!th[i]) return i;
        return -1;
    endfunction

    // Decodes every frame on the recorded tx history and compares each one,
    // cycle by cycle, with the ideal waveform of the expected byte.
    task automatic analyze(input string tag, input int a,
                           input logic [7:0] exp[$],
                           output int last_end, output int min_gap);
        int i    = a;
        int n    = 0;
        int prev = -1;
        int inc  = 0;
        last_end = -1;
        min_gap  = 1 << 30;
        while (i < th.size()) begin
            if (th[i]) begin
                i++;
                continue;
            end
            if (i + FL > th.size()) begin
                inc = 1;
                break;
            end
            if (prev >= 0 && i - prev < min_gap) min_gap = i - prev;
            if (n < exp.size()) begin
                logic [7:0] dec;
                int errs;
                bit e;
                errs = 0;
                for (int k = 0; k < W; k++)
                    dec[k] = th[i + CPB * (k + 1) + CPB / 2];
                for (int k = 0; k < FL; k++) begin
                    if (k < CPB) e = 1'b0;
                    else if (k < CPB * (W + 1)) e = exp[n][(k - CPB) / CPB];
                    else e = 1'b1;
                    if (th[i + k] != e) errs++;
                    if (dh[i + k] != (k == FL - 1)) errs++;
                end
                chk({tag, " byte"}, dec, exp[n]);
                chk({tag, " wave_errs"}, errs, 0);
            end
            n++;
            i        = i + FL;
            prev     = i;
            last_end = i;
        end
        chk({tag, " frames"}, n, exp.size());
        chk({tag, " partial"}, inc, 0);
    endtask

    initial begin
        int a, le, mg, r, e;
        string tg;

        tbl[0] = '{1'b1, 1, 8'h55, 8'h00, 1, -1};
        tbl[1] = '{1'b1, 2, 8'hA5, 8'h3C, 2, 3};
        tbl[2] = '{1'b1, 0, 8'h00, 8'h00, 0, -1};
        tbl[3] = '{1'b0, 1, 8'h12, 8'h00, 0, -1};
        tbl[4] = '{1'b1, 2, 8'hFF, 8'h00, 2, 3};

        rst = 1'b1; tx_enable = 1'b0; fifo_empty = 1'b1;
        fifo_out_valid = 1'b0; fifo_output = '0;
        tick();
        tick();
        chk("rst tx", tx, 1);
        chk("rst read_en", fifo_read_en, 0);
        chk("rst busy", tx_busy, 0);
        chk("rst done", frame_done, 0);
        chk("rst err", fetch_err, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            tg = $sformatf("vec%0d", v);
            ex.delete();
            tx_enable = tbl[v].en;
            a = th.size();
            if (tbl[v].n > 0) push(tbl[v].b0);
            if (tbl[v].n > 1) push(tbl[v].b1);
            if (tbl[v].frames > 0) ex.push_back(tbl[v].b0);
            if (tbl[v].frames > 1) ex.push_back(tbl[v].b1);
            repeat (110) tick();
            analyze(tg, a, ex, le, mg);
            chk({tg, " reads"}, n_ren(a), tbl[v].frames);
            chk({tg, " read_adjacent"}, n_adj(a), 0);
            chk({tg, " busy_cycles"}, n_busy(a), tbl[v].frames * (FL + 2));
            if (tbl[v].frames > 0) begin
                chk({tg, " fetch_latency"}, first_low(a) - first_ren(a), 2);
                if (le > 0 && le < bh.size())
                    chk({tg, " busy_drop"}, {bh[le-1], bh[le]}, 2'b10);
            end
            if (tbl[v].gap >= 0) chk({tg, " gap"}, mg, tbl[v].gap);
            tx_enable = 1'b0;
            q.delete();
            fifo_empty = 1'b1;
            repeat (5) tick();
        end

        // Enable dropped mid-frame: frame completes, nothing more is popped.
        tx_enable = 1'b1;
        a = th.size();
        push(8'h96);
        push(8'h5A);
        for (int k = 0; k < 20 && tx; k++) tick();
        chk("drop tx_fell", tx, 0);
        repeat (10) tick();
        tx_enable = 1'b0;
        repeat (150) tick();
        ex.delete();
        ex.push_back(8'h96);
        analyze("drop", a, ex, le, mg);
        chk("drop reads", n_ren(a), 1);
        chk("drop fifo_left", q.size(), 1);
        q.delete();
        fifo_empty = 1'b1;
        repeat (3) tick();

        // FIFO never answers: abort after the wait budget, then recover.
        mute = 1'b1;
        tx_enable = 1'b1;
        a = th.size();
        push(8'h00);
        for (int k = 0; k < 30 && !fetch_err; k++) tick();
        chk("timeout err_set", fetch_err, 1);
        e = th.size() - 1;
        r = first_ren(a);
        chk("timeout err_delay", e - r, TO + 1);
        repeat (10) tick();
        chk("timeout reads", n_ren(a), 1);
        chk("timeout tx_low", n_low(a), 0);
        chk("timeout busy_cycles", n_busy(a), 1 + TO);
        mute = 1'b0;
        a = th.size();
        push(8'h7E);
        repeat (60) tick();
        ex.delete();
        ex.push_back(8'h7E);
        analyze("after_timeout", a, ex, le, mg);
        chk("timeout err_sticky", fetch_err, 1);

        // Reset during data bit 3 of 0xC3, then a clean frame of 0x81.
        push(8'hC3);
        for (int k = 0; k < 20 && tx; k++) tick();
        chk("midrst tx_fell", tx, 0);
        repeat (CPB * 4 + 1) tick();
        rst = 1'b1;
        tick();
        chk("midrst tx", tx, 1);
        chk("midrst busy", tx_busy, 0);
        chk("midrst read_en", fifo_read_en, 0);
        chk("midrst err_cleared", fetch_err, 0);
        rst = 1'b0;
        a = th.size();
        push(8'h81);
        repeat (60) tick();
        ex.delete();
        ex.push_back(8'h81);
        analyze("midrst", a, ex, le, mg);

        // Random arrivals with stray valid strobes; every byte must emerge in order.
        stray = 1'b1;
        tx_enable = 1'b1;
        a = th.size();
        ex.delete();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                logic [7:0] b;
                b = 8'($urandom);
                push(b);
                ex.push_back(b);
            end
            tick();
        end
        for (int c = 0; c < 4000 && (q.size() > 0 || tx_busy || pend); c++)
            tick();
        repeat (5) tick();
        analyze("rnd", a, ex, le, mg);
        chk("rnd drained", q.size() + int'(tx_busy), 0);
        chk("rnd reads", n_ren(a), ex.size());
        chk("rnd read_adjacent", n_adj(a), 0);
        chk("rnd gap_ge_3", int'(mg >= 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Consumer-side partner of the UART/console FIFO: pops bytes from the FIFO read port and serializes each as an 8N1-style asynchronous frame on a single `tx` line.
- Sits between the CPU-facing MMIO FIFO and the board UART TX pin.
- Owns the FIFO read handshake:
  - the FIFO pops only on a rising edge of its read-enable;
  - the FIFO returns data one cycle later with a single-cycle valid strobe.

Parameters:
- WIDTH, 8, data bits per frame; must match FIFO WIDTH.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.
- STOP_BITS, 1, number of stop bits, legal values 1 or 2.
- FETCH_TIMEOUT, 4, max cycles spent in WAIT for fifo_out_valid before aborting.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tx_enable  input  1  level; permits starting new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_out_valid  input  1  FIFO one-cycle data-valid strobe.
- fifo_output  input  WIDTH  FIFO read data; valid only while fifo_out_valid=1.
- fifo_read_en  output  1  pop request; registered single-cycle pulse.
- tx  output  1  serial line; idle high; registered.
- tx_busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.
- fetch_err  output  1  sticky; set on fetch timeout; cleared only by rst.

Behaviour:
- Reset values: tx=1, fifo_read_en=0, tx_busy=0, frame_done=0, fetch_err=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: applies next edge; tx returns high immediately and the in-flight byte is lost. No partial-frame completion.
- FSM states and transitions:
  - IDLE: tx=1. If tx_enable && !fifo_empty, go to REQ.
  - REQ: exactly one cycle with fifo_read_en=1; next state is WAIT.
  - WAIT: fifo_read_en=0, tx=1, wait counter increments.
    - If fifo_out_valid=1: latch fifo_output into the shift register, go to START.
    - Else, when the counter reaches FETCH_TIMEOUT: set fetch_err, go to IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift register bit 0, LSB first, each bit held CLKS_PER_BIT cycles. Shift right after each bit. After WIDTH bits, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the final cycle. Next state is IDLE.
- fifo_read_en is never high in two consecutive cycles and is always low for at least one cycle between pulses. This guarantees a clean rising edge per pop.
- Fetch latency: condition seen in IDLE at cycle N; REQ at N+1; valid expected at N+2 (WAIT); tx falls at N+3.
- Frame length: (1 + WIDTH + STOP_BITS) * CLKS_PER_BIT cycles, from the first tx=0 cycle to the end of STOP.
- Back-to-back bytes: minimum 3 idle-high cycles between frames (IDLE, REQ, WAIT). fifo_empty is re-sampled in IDLE each time.
- tx_enable handling:
  - sampled only in IDLE;
  - deasserting it mid-frame (REQ through STOP) does not abort; the current frame completes.
- A fifo_out_valid arriving in any state other than WAIT is ignored.
- Baud counter width is clog2(CLKS_PER_BIT). Bit counter width is clog2(WIDTH+1). Neither wraps inside a state.
- fetch_err does not stall operation; subsequent pops proceed normally.

Test Plan:
- Single byte: CLKS_PER_BIT=4, FIFO holds 0x55, tx_enable=1.
  - One fifo_read_en pulse; tx falls 3 cycles after leaving IDLE.
  - tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; frame_done at cycle 40 of the frame.
  - tx_busy deasserts on the return to IDLE.
- Back-to-back: FIFO holds 0xA5 then 0x3C.
  - Two frames: LSB-first bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - Exactly 3 tx-high cycles between the stop bit and the next start bit.
  - fifo_read_en pulses are separated by at least one low cycle.
- Empty/disabled:
  - fifo_empty=1, tx_enable=1 for 100 cycles: fifo_read_en never asserts, tx=1, tx_busy=0.
  - Then fifo_empty=0 with tx_enable=0: still no read.
- Enable drop mid-frame: deassert tx_enable during DATA.
  - The frame completes with correct bits.
  - No further REQ occurs while tx_enable=0, even with the FIFO non-empty.
- Fetch timeout: model the FIFO never asserting fifo_out_valid.
  - fetch_err=1 after FETCH_TIMEOUT WAIT cycles; return to IDLE; tx never falls.
  - Next valid byte 0x7E is transmitted correctly with fetch_err still 1.
- Reset mid-frame: assert rst for 1 cycle during bit 3 of 0xC3.
  - tx=1, tx_busy=0, fifo_read_en=0 on the next cycle.
  - The following byte 0x81 is transmitted as a clean full frame.
